// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing the 8x64 register file access path between the host (m0) and the factorial core (m1).
// Optional ARB_LOCK_EN adds m0_lock/m1_lock so a winner can hold priority across consecutive accesses.
module rf_access_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
`ifdef ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dbg_state,
  output logic              dbg_rr_ptr
);

  // Handshake: a master raises req with wr/addr/wdata stable and holds them
  // until it sees its one-cycle gnt; gnt means the command was consumed and
  // the master may change or drop req from the next cycle. Reads answer with
  // a one-cycle rvalid the cycle after gnt; rdata then holds until that
  // master's next read completes.

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                win_q, win_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                m0_rvalid_q, m0_rvalid_d;
  logic                m1_rvalid_q, m1_rvalid_d;
  logic                pick;
  logic                winner_lock;

  // A lone requester always wins; rr_ptr only breaks ties.
  assign pick = (m0_req && m1_req) ? rr_ptr_q : m1_req;

`ifdef ARB_LOCK_EN
  assign winner_lock = win_q ? m1_lock : m0_lock;
`else
  assign winner_lock = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    rf_we       = 1'b0;
    rf_addr     = '0;
    rf_wdata    = '0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          win_d       = pick;
          cmd_wr_d    = pick ? m1_wr    : m0_wr;
          cmd_addr_d  = pick ? m1_addr  : m0_addr;
          cmd_wdata_d = pick ? m1_wdata : m0_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        rf_we    = cmd_wr_q;
        rf_addr  = cmd_addr_q;
        rf_wdata = cmd_wdata_q;
        m0_gnt   = ~win_q;
        m1_gnt   = win_q;
        if (!cmd_wr_q) begin
          if (win_q) begin
            m1_rdata_d  = rf_rdata;
            m1_rvalid_d = 1'b1;
          end else begin
            m0_rdata_d  = rf_rdata;
            m0_rvalid_d = 1'b1;
          end
        end
        // A locked winner keeps the tie-break for the following IDLE.
        rr_ptr_d = winner_lock ? win_q : ~win_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      win_q       <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign m0_rvalid  = m0_rvalid_q;
  assign m1_rvalid  = m1_rvalid_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural 8x64 register file; lock scenario runs when ARB_LOCK_EN is defined.
module tb_rf_access_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              m0_req = 1'b0, m0_wr = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m1_req = 1'b0, m1_wr = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m0_lock = 1'b0, m1_lock = 1'b0;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;
  logic              dbg_state, dbg_rr_ptr;

  logic [DATA_W-1:0] rf_mem [8];
  int checks = 0;
  int errors = 0;

  rf_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
`ifdef ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // Clock / register file model
  always #5 clk = ~clk;

  assign rf_rdata = rf_mem[rf_addr];
  always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return {32'hA5A5_0000, 32'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
    m0_lock = 1'b0; m1_lock = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b expected 00", m0_gnt, m1_gnt); end
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", m0_rvalid, m1_rvalid); end
    checks++; if (rf_we !== 1'b0 || rf_addr !== 3'd0 || rf_wdata !== 64'd0) begin errors++; $display("FAIL reset_rf: got we=%b addr=%0d wdata=%h expected 0/0/0", rf_we, rf_addr, rf_wdata); end
    checks++; if (m0_rdata !== 64'd0 || m1_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata); end
    checks++; if (dbg_state !== 1'b0 || dbg_rr_ptr !== 1'b0) begin errors++; $display("FAIL reset_state: got state=%b rr=%b expected 0 0", dbg_state, dbg_rr_ptr); end
    reset = 1'b0;
    tick();
    checks++; if (dbg_state !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_idle: got state=%b gnt=%b%b expected 0 00", dbg_state, m0_gnt, m1_gnt); end
  endtask

  task automatic test_write_m0();
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 3'd5; m0_wdata = 64'h0000_0000_0000_0078;
    tick();
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL wr_m0_gnt: got %b%b expected m0=1 m1=0", m0_gnt, m1_gnt); end
    checks++; if (rf_we !== 1'b1 || rf_addr !== 3'd5 || rf_wdata !== 64'h78) begin errors++; $display("FAIL wr_m0_rf: got we=%b addr=%0d wdata=%h expected 1/5/78", rf_we, rf_addr, rf_wdata); end
    clear_inputs();
    tick();
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL wr_m0_norvalid: got rv=%b%b we=%b expected 00 0", m0_rvalid, m1_rvalid, rf_we); end
    checks++; if (rf_mem[5] !== 64'h78) begin errors++; $display("FAIL wr_m0_commit: got %h expected 78", rf_mem[5]); end
    checks++; if (dbg_rr_ptr !== 1'b1) begin errors++; $display("FAIL wr_m0_rr: got %b expected 1", dbg_rr_ptr); end
  endtask

  task automatic test_read_m1();
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 3'd5;
    tick();
    checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++; $display("FAIL rd_m1_gnt: got m0=%b m1=%b expected 0 1", m0_gnt, m1_gnt); end
    checks++; if (rf_we !== 1'b0 || rf_addr !== 3'd5) begin errors++; $display("FAIL rd_m1_rf: got we=%b addr=%0d expected 0/5", rf_we, rf_addr); end
    clear_inputs();
    tick();
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 64'h78) begin errors++; $display("FAIL rd_m1_data: got rv=%b data=%h expected 1/78", m1_rvalid, m1_rdata); end
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 64'd0 || m0_gnt !== 1'b0) begin errors++; $display("FAIL rd_m1_m0quiet: got rv=%b data=%h gnt=%b expected 0/0/0", m0_rvalid, m0_rdata, m0_gnt); end
    tick();
    checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 64'h78) begin errors++; $display("FAIL rd_m1_hold: got rv=%b data=%h expected 0/78", m1_rvalid, m1_rdata); end
  endtask

  task automatic test_write_read_same();
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 3'd6; m0_wdata = 64'hDEAD_BEEF_0123_4567;
    tick();
    checks++; if (m0_gnt !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL wrrd_wgnt: got gnt=%b we=%b expected 1 1", m0_gnt, rf_we); end
    m0_wr = 1'b0;
    tick();
    checks++; if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin errors++; $display("FAIL wrrd_idle: got rv=%b gnt=%b expected 0 0", m0_rvalid, m0_gnt); end
    tick();
    checks++; if (m0_gnt !== 1'b1 || rf_we !== 1'b0 || rf_addr !== 3'd6) begin errors++; $display("FAIL wrrd_rgnt: got gnt=%b we=%b addr=%0d expected 1/0/6", m0_gnt, rf_we, rf_addr); end
    clear_inputs();
    tick();
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL wrrd_data: got rv=%b data=%h expected 1/deadbeef01234567", m0_rvalid, m0_rdata); end
  endtask

  task automatic test_contention();
    logic w;
    do_reset();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 3'd1;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 3'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      w = ((i / 2) % 2) == 1;
      if (i % 2 == 0) begin
        checks++; if (m0_gnt !== ~w || m1_gnt !== w) begin errors++; $display("FAIL cont_gnt[%0d]: got m0=%b m1=%b expected m0=%b m1=%b", i, m0_gnt, m1_gnt, ~w, w); end
        checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL cont_rv_in_issue[%0d]: got %b%b expected 00", i, m0_rvalid, m1_rvalid); end
      end else begin
        checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m0_rvalid !== ~w || m1_rvalid !== w) begin errors++; $display("FAIL cont_rv[%0d]: got gnt=%b%b rv=%b%b expected gnt=00 rv m0=%b m1=%b", i, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ~w, w); end
        if (w) begin
          checks++; if (m1_rdata !== init_val(2)) begin errors++; $display("FAIL cont_m1_data[%0d]: got %h expected %h", i, m1_rdata, init_val(2)); end
        end else begin
          checks++; if (m0_rdata !== init_val(1)) begin errors++; $display("FAIL cont_m0_data[%0d]: got %h expected %h", i, m0_rdata, init_val(1)); end
        end
      end
    end
    clear_inputs();
    tick();
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL cont_drain: got gnt=%b%b rv=%b%b expected all 0", m0_gnt, m1_gnt, m0_rvalid, m1_rvalid); end
  endtask

  task automatic test_reset_mid_issue();
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 3'd3; m0_wdata = 64'h3333_3333_3333_3333;
    tick();
    checks++; if (rf_we !== 1'b1 || m0_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got we=%b gnt=%b expected 1 1", rf_we, m0_gnt); end
    #2 reset = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || m0_gnt !== 1'b0 || rf_addr !== 3'd0) begin errors++; $display("FAIL rst_mid_async: got we=%b gnt=%b addr=%0d expected 0/0/0", rf_we, m0_gnt, rf_addr); end
    checks++; if (dbg_state !== 1'b0 || dbg_rr_ptr !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got state=%b rr=%b expected 0 0", dbg_state, dbg_rr_ptr); end
    clear_inputs();
    tick();
    checks++; if (rf_mem[3] !== init_val(3)) begin errors++; $display("FAIL rst_mid_abort: got %h expected %h", rf_mem[3], init_val(3)); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet[%0d]: got gnt=%b%b rv=%b%b expected all 0", i, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid); end
    end
  endtask

  task automatic test_single_m1();
    int grants;
    grants = 0;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 3'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m1_gnt === 1'b1) grants++;
      checks++; if (m1_gnt !== (i % 2 == 0) || m0_gnt !== 1'b0) begin errors++; $display("FAIL single_gnt[%0d]: got m0=%b m1=%b expected m0=0 m1=%b", i, m0_gnt, m1_gnt, (i % 2 == 0)); end
      if (i % 2 == 1) begin
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== init_val(2)) begin errors++; $display("FAIL single_rv[%0d]: got rv=%b data=%h expected 1/%h", i, m1_rvalid, m1_rdata, init_val(2)); end
      end
    end
    clear_inputs();
    tick();
    checks++; if (grants !== 4) begin errors++; $display("FAIL single_count: got %0d expected 4", grants); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic w;
    do_reset();
    m0_lock = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 3'd1;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 3'd2;
    for (int i = 0; i < 8; i += 2) begin
      tick();
      w = (i == 6);
      checks++; if (m0_gnt !== ~w || m1_gnt !== w) begin errors++; $display("FAIL lock_gnt[%0d]: got m0=%b m1=%b expected m0=%b m1=%b", i, m0_gnt, m1_gnt, ~w, w); end
      tick();
      if (i == 2) m0_lock = 1'b0;
    end
    clear_inputs();
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = init_val(i);
    test_reset();
    test_write_m0();
    test_read_m1();
    test_write_read_same();
    test_contention();
    test_reset_mid_issue();
    test_single_m1();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Grants and rvalids are one-hot by construction; flag any overlap.
  always @(negedge clk) begin
    if (!reset) begin
      checks++; if ((m0_gnt && m1_gnt) || (m0_rvalid && m1_rvalid)) begin errors++; $display("FAIL onehot: got gnt=%b%b rv=%b%b expected at most one each", m0_gnt, m1_gnt, m0_rvalid, m1_rvalid); end
    end
  end

endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

Two-port access arbiter for the 8×64-bit register file of the factorial computation system.
- Shares the file's single read/write access path between the host interface (master 0) and the factorial core (master 1), with round-robin fairness.
- Drives the register file's write enable, address and write data.
- Captures the file's read-mux output and returns it to the winning master with a valid strobe.

## Interface
Parameters:
- DATA_W, 64, register data width
- ADDR_W, 3, register address width (8 registers)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 access request, held until m0_gnt seen
- m0_wr  in  1  master 0: 1 = write, 0 = read
- m0_addr  in  ADDR_W  master 0 register address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  master 0 grant pulse
- m0_rdata  out  DATA_W  master 0 read data
- m0_rvalid  out  1  master 0 read data valid pulse
- m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as master 0, for master 1
- rf_we  out  1  register file write enable
- rf_addr  out  ADDR_W  register file address (write select and read-mux select)
- rf_wdata  out  DATA_W  register file write data
- rf_rdata  in  DATA_W  register file read-mux output (combinational from rf_addr)
- m0_lock, m1_lock  in  1  hold-grant request (present only with ARB_LOCK_EN)

## Operation
FSM states: IDLE, ISSUE.

IDLE:
- If no req is asserted, stay in IDLE.
- Else pick a winner:
  - Only one req asserted: that master wins.
  - Both asserted: the master indicated by rr_ptr wins.
- Latch the winner's wr, addr and wdata into command registers; go to ISSUE.

ISSUE:
- rf_we = latched wr; rf_addr, rf_wdata = latched values.
- Winner's gnt = 1.
- At the clock edge:
  - If read: capture rf_rdata into the winner's rdata register and set the winner's rvalid for the next cycle.
  - rr_ptr ← the master that did not win.
  - Return to IDLE.

Grant and data outputs:
- The gnt pulse means the command has been consumed. The master may change req/wr/addr/wdata from the following cycle.
- m*_rdata holds its value until the next read completes for that master.
- Writes produce no rvalid.
- At most one of m0_gnt/m1_gnt is high; at most one of m0_rvalid/m1_rvalid is high.
- In IDLE: rf_we = 0, rf_addr = 0, rf_wdata = 0.
- Requests deasserted in IDLE before a grant are dropped silently; no state change.
- Address and data widths pass through unmodified; there is no arithmetic.

## Timing
- Reset values: state IDLE, rr_ptr = 0 (master 0 favoured first), all gnt/rvalid/rf_we = 0, rf_addr = 0, rf_wdata = 0, m*_rdata = 0.
- Latency:
  - req sampled high at edge N → gnt and rf_we high in cycle N+1.
  - Read data and rvalid valid in cycle N+2, aligned with the next IDLE cycle.
- Throughput: one access every 2 cycles. A master holding req continuously after its grant is re-arbitrated in the IDLE cycle.
- Contention: with both masters requesting continuously, grants alternate 0,1,0,1…
- Reset mid-operation:
  - Outputs go to reset values asynchronously; in-flight writes are aborted (rf_we drops immediately).
  - No rvalid is issued for an aborted read.
- A write followed by a read of the same address (either master): the read returns the new value, because the write commits at the end of ISSUE, before the next ISSUE.

## Configuration
- ARB_LOCK_EN defined:
  - m0_lock/m1_lock ports exist.
  - If the winner's lock is high during ISSUE, rr_ptr is not advanced and the winner keeps priority in the next IDLE. If that master is not requesting in that IDLE, the other master may win.
  - Lock has no length limit.
- ARB_LOCK_EN undefined: lock ports are absent; rr_ptr always advances after each grant.

## Test plan
- Reset, then m0 writes 64'h0000_0000_0000_0078 to addr 5 → m0_gnt and rf_we pulse in cycle 1 with rf_addr = 5; no rvalid.
- m1 reads addr 5 after the above write → m1_gnt in cycle 1; m1_rvalid in cycle 2 with m1_rdata = 64'h78; m0 outputs stay 0.
- Both masters request reads continuously from reset (addr 1 and addr 2) → grants alternate m0, m1, m0, m1; each gnt pulse is 2 cycles apart; rvalid one cycle after each gnt.
- Assert reset during ISSUE of an m0 write to addr 3 → rf_we falls immediately; state IDLE; no gnt/rvalid afterward until a new req; rr_ptr = 0.
- Single requester m1 holding req for 4 accesses → m1 granted every 2 cycles; rr_ptr never blocks it.
- With ARB_LOCK_EN, m0_lock = 1 and both masters requesting → m0 is granted 3 times in a row; when m0_lock drops, the next grant goes to m1.
